// File: rtl/mem_access_stage.sv
// MEM stage: word-organised data memory with byte/half/word access,
// fixed multi-cycle latency, upstream stall and MEM/WB output registers.
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  dest_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic        flush,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  dest_reg_out,
    output logic        reg_write_out,
    output logic        misalign_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_byte, is_half;
    logic          mem_op, misaligned, aligned_op;
    logic          done, we;
    logic [3:0]    be;
    logic [31:0]   wlanes, rword, load_val;
    logic [7:0]    bsel;
    logic [15:0]   hsel;

    assign idx        = alu_result_in[AW+1:2];
    assign lane       = alu_result_in[1:0];
    assign is_byte    = (mem_size_in == 2'b00);
    assign is_half    = (mem_size_in == 2'b01);
    assign mem_op     = valid_in & (mem_read_in | mem_write_in);
    assign misaligned = (is_half & lane[0])
                      | (~is_byte & ~is_half & (lane != 2'b00));
    assign aligned_op = mem_op & ~misaligned;
    assign we         = done & mem_write_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Flush or a vanished instruction aborts an access without touching memory
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && aligned_op) begin
                    stall    = 1'b1;
                    state_nx = WAIT;
                    cnt_nx   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (flush || !valid_in) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt != 4'd0) begin
                    stall  = 1'b1;
                    cnt_nx = cnt - 4'd1;
                end else begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_comb begin
        be     = 4'b1111;
        wlanes = write_data_in;
        if (is_byte) begin
            be     = 4'b0001 << lane;
            wlanes = {4{write_data_in[7:0]}};
        end else if (is_half) begin
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{write_data_in[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        rword = mem[idx];
        bsel  = rword[{lane, 3'b000} +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];
        if (is_byte)
            load_val = mem_unsigned_in ? {24'd0, bsel}
                                       : {{24{bsel[7]}}, bsel};
        else if (is_half)
            load_val = mem_unsigned_in ? {16'd0, hsel}
                                       : {{16{hsel[15]}}, hsel};
        else
            load_val = rword;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            dest_reg_out   <= '0;
            reg_write_out  <= 1'b0;
            misalign_out   <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            misalign_out  <= 1'b0;
            if (flush || !valid_in) begin
                // data outputs hold
            end else if (state == IDLE && !mem_op) begin
                valid_out      <= 1'b1;
                read_data_out  <= '0;
                alu_result_out <= alu_result_in;
                dest_reg_out   <= dest_reg_in;
                reg_write_out  <= reg_write_in;
            end else if (state == IDLE && misaligned) begin
                valid_out      <= 1'b1;
                misalign_out   <= 1'b1;
                read_data_out  <= '0;
                alu_result_out <= alu_result_in;
                dest_reg_out   <= dest_reg_in;
            end else if (done) begin
                valid_out      <= 1'b1;
                read_data_out  <= mem_read_in ? load_val : '0;
                alu_result_out <= alu_result_in;
                dest_reg_out   <= dest_reg_in;
                reg_write_out  <= reg_write_in;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: random and directed instructions checked
// cycle by cycle against a transaction-level memory model.
module tb_mem_access_stage;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk, rst_n;
    logic        valid_in, reg_write_in, mem_read_in, mem_write_in;
    logic        mem_unsigned_in, flush;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  dest_reg_in;
    logic [1:0]  mem_size_in;
    logic        stall, valid_out, reg_write_out, misalign_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  dest_reg_out;

    mem_access_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .dest_reg_in(dest_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .flush(flush), .stall(stall), .valid_out(valid_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .dest_reg_out(dest_reg_out), .reg_write_out(reg_write_out),
        .misalign_out(misalign_out)
    );

    typedef struct {
        bit          v, rw, mis;
        logic [31:0] alu, rd;
        logic [4:0]  dest;
    } exp_t;

    exp_t        exp_out[int];
    bit          exp_stall[int];
    logic [31:0] model[DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mload(logic [31:0] w, logic [1:0] sz,
                                          bit us, logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = 16'(w >> (16 * a[1]));
        if (sz == 2'd0) return us ? {24'd0, b} : {{24{b[7]}}, b};
        if (sz == 2'd1) return us ? {16'd0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] mstore(logic [31:0] w, logic [1:0] sz,
                                           logic [1:0] a, logic [31:0] d);
        logic [31:0] m, s;
        if (sz == 2'd0) begin
            m = 32'hFF << (8 * a);
            s = (d & 32'hFF) << (8 * a);
        end else if (sz == 2'd1) begin
            m = 32'hFFFF << (16 * a[1]);
            s = (d & 32'hFFFF) << (16 * a[1]);
        end else begin
            m = 32'hFFFF_FFFF;
            s = d;
        end
        return (w & ~m) | s;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (rst_n) begin
            if (exp_stall.exists(cyc)) chk("stall", stall, exp_stall[cyc]);
            if (exp_out.exists(cyc)) begin
                e = exp_out[cyc];
                chk("valid_out", valid_out, e.v);
                chk("reg_write_out", reg_write_out, e.rw);
                chk("misalign_out", misalign_out, e.mis);
                if (e.v) begin
                    chk("alu_result_out", alu_result_out, e.alu);
                    chk("dest_reg_out", dest_reg_out, e.dest);
                    chk("read_data_out", read_data_out, e.rd);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge at which
    // the instruction's result becomes visible.
    task automatic issue(input bit v, input bit rd, input bit wr,
                         input logic [1:0] sz, input bit us,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] dst, input bit rw,
                         input int flush_at, output logic [31:0] exp_rd);
        int   c, n, wi;
        bit   memop, mis;
        exp_t e, bub;
        logic [31:0] lv;
        c     = cyc;
        memop = v && (rd || wr);
        mis   = (sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'd0);
        n     = (memop && !mis) ? LATENCY + 1 : 1;
        if (flush_at >= 0 && flush_at < n) n = flush_at + 1;
        else flush_at = -1;
        bub = '{v: 0, rw: 0, mis: 0, alu: 0, rd: 0, dest: 0};
        for (int k = 0; k < n; k++) exp_stall[c + k] = (k < n - 1);
        for (int k = 1; k < n; k++) exp_out[c + k] = bub;
        e = bub;
        if (v && flush_at < 0) begin
            e.v = 1; e.alu = addr; e.dest = dst;
            if (!memop) begin
                e.rw = rw;
            end else if (mis) begin
                e.mis = 1;
            end else begin
                wi = int'((addr >> 2) % DEPTH);
                lv = mload(model[wi], sz, us, addr[1:0]);
                if (wr) model[wi] = mstore(model[wi], sz, addr[1:0], wd);
                e.rw = rw;
                e.rd = rd ? lv : 32'd0;
            end
        end
        exp_out[c + n] = e;
        exp_rd = e.rd;
        valid_in = v; mem_read_in = rd; mem_write_in = wr;
        mem_size_in = sz; mem_unsigned_in = us; alu_result_in = addr;
        write_data_in = wd; dest_reg_in = dst; reg_write_in = rw;
        flush = 0;
        for (int k = 0; k < n; k++) begin
            if (k == flush_at) flush = 1;
            @(posedge clk);
            #1;
        end
        valid_in = 0; flush = 0;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        issue(1, 0, 1, 2'd2, 0, a, d, 5'd0, 0, -1, r);
    endtask

    task automatic ld(input logic [1:0] sz, input bit us,
                      input logic [31:0] a, input logic [4:0] dst,
                      output logic [31:0] r);
        issue(1, 1, 0, sz, us, a, 32'd0, dst, 1, -1, r);
    endtask

    initial begin : main
        logic [31:0] r, old, a, d;
        logic [1:0]  sz;
        int          kind, fa;
        rst_n = 0; valid_in = 1; mem_read_in = 1; mem_write_in = 0;
        mem_size_in = 2'd2; mem_unsigned_in = 0; alu_result_in = 32'h10;
        write_data_in = 0; dest_reg_in = 0; reg_write_in = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_rd", read_data_out, 0);
        chk("rst_alu", alu_result_out, 0);
        chk("rst_dest", dest_reg_out, 0);
        chk("rst_rw", reg_write_out, 0);
        chk("rst_mis", misalign_out, 0);
        valid_in = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) sw(32'(i * 4), $urandom);

        sw(32'h10, 32'hDEADBEEF);
        ld(2'd2, 0, 32'h10, 5'd7, r);
        chk("model_lw", r, 32'hDEADBEEF);
        chk("lw_data", read_data_out, 32'hDEADBEEF);
        chk("lw_dest", dest_reg_out, 5'd7);

        sw(32'h20, 32'h80FF7F01);
        ld(2'd0, 0, 32'h23, 5'd1, r);
        chk("lb_data", read_data_out, 32'hFFFFFF80);
        ld(2'd0, 1, 32'h23, 5'd2, r);
        chk("lbu_data", read_data_out, 32'h00000080);
        ld(2'd1, 0, 32'h22, 5'd3, r);
        chk("lh_data", read_data_out, 32'hFFFF80FF);
        ld(2'd1, 1, 32'h20, 5'd4, r);
        chk("lhu_data", read_data_out, 32'h00007F01);

        sw(32'h20, 32'h11223344);
        issue(1, 0, 1, 2'd0, 0, 32'h21, 32'h000000AA, 5'd0, 0, -1, r);
        ld(2'd2, 0, 32'h20, 5'd5, r);
        chk("model_sb", r, 32'h1122AA44);
        chk("sb_lw_data", read_data_out, 32'h1122AA44);

        ld(2'd2, 0, 32'h06, 5'd9, r);
        chk("mis_lw_flag", misalign_out, 1);
        chk("mis_lw_rw", reg_write_out, 0);
        issue(1, 0, 1, 2'd1, 0, 32'h03, 32'hFFFF, 5'd0, 1, -1, r);
        chk("mis_sh_flag", misalign_out, 1);
        ld(2'd2, 0, 32'h04, 5'd6, r);

        ld(2'd2, 0, 32'h10, 5'd8, r);
        issue(1, 0, 0, 2'd2, 0, 32'h12345, 32'd0, 5'd5, 1, -1, r);
        chk("addu_alu", alu_result_out, 32'h12345);
        chk("addu_rd", read_data_out, 32'd0);

        old = model[16];
        issue(1, 0, 1, 2'd2, 0, 32'h40, 32'h12345678, 5'd0, 0, LATENCY, r);
        ld(2'd2, 0, 32'h40, 5'd10, r);
        chk("flush_old", read_data_out, old);

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            d    = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            fa = ($urandom_range(0, 7) == 0)
               ? int'($urandom_range(0, LATENCY)) : -1;
            if (kind == 0)
                issue(0, 1'($urandom), 1'($urandom), sz, 0, a, d,
                      5'($urandom), 1, fa, r);
            else if (kind <= 2)
                issue(1, 0, 0, sz, 0, a, d, 5'($urandom), 1'($urandom), fa, r);
            else if (kind <= 6)
                issue(1, 1, 0, sz, 1'($urandom), a, d, 5'($urandom),
                      1'($urandom), fa, r);
            else
                issue(1, 0, 1, sz, 0, a, d, 5'($urandom), 1'($urandom), fa, r);
        end

        old = model[17];
        valid_in = 1; mem_read_in = 0; mem_write_in = 1; mem_size_in = 2'd2;
        alu_result_in = 32'h44; write_data_in = 32'h55555555;
        @(negedge clk);
        chk("pre_rst_stall", stall, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_rd", read_data_out, 0);
        chk("mid_rst_alu", alu_result_out, 0);
        chk("mid_rst_dest", dest_reg_out, 0);
        chk("mid_rst_rw", reg_write_out, 0);
        valid_in = 0; mem_write_in = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        ld(2'd2, 0, 32'h44, 5'd11, r);
        chk("rst_nowrite", read_data_out, old);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory stage of the 5-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register. It holds a word-organised data memory and performs byte, halfword and word loads and stores with a configurable access latency, stalling upstream while busy. It passes the ALU result and destination register through, and registers everything consumed by MEM/WB (read data, address/ALU result, dest reg).

Parameters:
DEPTH, 256, number of 32-bit words in data memory; must be a power of 2
LATENCY, 2, wait cycles per memory access; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  EX/MEM slot holds a real instruction
alu_result_in  input  32  byte address for mem ops / ALU result otherwise
write_data_in  input  32  store data (rt value)
dest_reg_in  input  5  destination register number
reg_write_in  input  1  instruction writes the register file
mem_read_in  input  1  load
mem_write_in  input  1  store
mem_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned_in  input  1  zero-extend loads (lbu/lhu)
flush  input  1  synchronous kill of the current instruction
stall  output  1  hold EX/MEM and earlier stages (combinational)
valid_out  output  1  outputs hold a completed instruction
read_data_out  output  32  load result, extended to 32 bits
alu_result_out  output  32  registered copy of alu_result_in
dest_reg_out  output  5  registered copy of dest_reg_in
reg_write_out  output  1  registered reg_write, forced 0 on misalign/flush
misalign_out  output  1  pulse: address misaligned for the access size

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, all registered outputs 0. stall=0 while in reset. Memory array is not cleared.
- FSM states: IDLE, WAIT.
- mem_op = valid_in & (mem_read_in | mem_write_in). misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Non-mem instruction (valid_in, no mem op): one cycle. Inputs are registered to outputs at the next edge, valid_out=1, read_data_out=0.
- Misaligned mem op: no stall and no memory access. Next edge: valid_out=1, misalign_out=1, reg_write_out=0, read_data_out=0.
- Aligned mem op in IDLE: stall=1, go to WAIT with cnt=LATENCY-1.
- WAIT with cnt!=0: stall=1, cnt decrements, valid_out=0 (bubble to MEM/WB).
- WAIT with cnt==0: stall=0. At that edge the store is committed or the load is captured, outputs are registered with valid_out=1, and the FSM returns to IDLE.
- Total occupancy of a mem op is LATENCY+1 cycles. Upstream holds all inputs stable while stall=1.
- Addressing: word index = alu_result_in[log2(DEPTH)+1:2]; upper bits are ignored and addresses wrap modulo DEPTH words. Byte lanes are little-endian: lane addr[1:0] maps to bits [8*lane+7:8*lane].
- Stores: sb writes lane addr[1:0] with write_data[7:0]. sh writes lanes addr[1]*2..+1 with write_data[15:0]. sw writes the full word. Other lanes are untouched.
- Loads: the selected byte or half is sign-extended, or zero-extended when mem_unsigned_in=1. A word load returns the raw word.
- Store: reg_write_out is the registered reg_write_in (0 for a correct store); read_data_out=0.
- valid_in=0: next edge drives valid_out=0, reg_write_out=0, misalign_out=0. Data outputs hold their values.
- flush=1: in IDLE, the instruction is dropped. In WAIT, the access aborts with no memory write and the FSM returns to IDLE. Either way the next edge drives valid_out=0 and reg_write_out=0. Flush wins over a completion in the same cycle. stall=0 whenever flush=1.
- Reset asserted mid-WAIT: the access aborts with no write, and the FSM returns to IDLE immediately.

Test Plan:
- LATENCY=2: sw 0xDEADBEEF to addr 0x10, then lw from 0x10 -> stall high 2 cycles per op; read_data_out=0xDEADBEEF, valid_out pulses once per op, dest_reg_out echoes.
- Word at 0x20 = 0x80FF7F01: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
- sb 0xAA to 0x21 over 0x11223344 -> lw 0x20 returns 0x1122AA44.
- lw at 0x06 and sh at 0x03 -> no stall, misalign_out=1, reg_write_out=0, memory unchanged.
- addu (no mem op) after a load -> completes one cycle after the load's valid_out; alu_result_out passes through, read_data_out=0.
- sw 0x12345678 to 0x40 with flush in its final WAIT cycle -> no write (later lw 0x40 returns the old value), valid_out=0. Reset pulsed mid-WAIT -> stall=0 immediately and all outputs 0.
